// File: rtl/accu_arbiter_if.sv
// Handshake bundle between NUM_REQ sample producers, the accumulator arbiter and the sum consumer.
// master = producer/consumer side, slave = arbiter side.
interface accu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int GROUP   = 4
);
    localparam int SUM_W = DATA_W + $clog2(GROUP);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SUM_W-1:0]          out_data;
    logic [ID_W-1:0]           out_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/accu_arbiter.sv
// Round-robin shared group-of-GROUP accumulator; ACCU_ARB_TIMEOUT_EN adds a stalled-grant abort.
// Latency: 1 arbitration cycle + GROUP beats, result valid the cycle after the last beat.
// Backpressure: result held until out_ready; no requester is granted while a result is pending.
module accu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int GROUP   = 4
`ifdef ACCU_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    accu_arbiter_if.slave        bus,
    output logic                 busy
`ifdef ACCU_ARB_TIMEOUT_EN
    ,
    output logic                 abort
`endif
);
    localparam int SUM_W = DATA_W + $clog2(GROUP);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(GROUP);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [SUM_W-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]    out_id_q, out_id_d;
    logic               out_valid_q, out_valid_d;
    logic [NUM_REQ-1:0] req_rdy;
    logic [DATA_W-1:0]  sel_dat;
    logic               win_vld;
    logic [ID_W-1:0]    win_id;
`ifdef ACCU_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic               abort_q, abort_d;
`endif

    assign sel_dat = bus.req_data[int'(grant_id_q)*DATA_W +: DATA_W];

    // First valid requester after last_grant, wrapping around.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_REQ;
            if (!win_vld && bus.req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        sum_d        = sum_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        out_valid_d  = out_valid_q;
        req_rdy      = '0;
`ifdef ACCU_ARB_TIMEOUT_EN
        idle_cnt_d   = idle_cnt_q;
        abort_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_id_d = win_id;
                    beat_cnt_d = '0;
                    state_d    = ACCUM;
`ifdef ACCU_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            ACCUM: begin
                req_rdy[grant_id_q] = 1'b1;
                if (bus.req_valid[grant_id_q]) begin
                    sum_d      = (beat_cnt_q == '0) ? SUM_W'(sel_dat) : sum_q + SUM_W'(sel_dat);
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
`ifdef ACCU_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (beat_cnt_q == CNT_W'(GROUP - 1)) begin
                        out_data_d  = sum_q + SUM_W'(sel_dat);
                        out_id_d    = grant_id_q;
                        out_valid_d = 1'b1;
                        state_d     = RESULT;
                    end
                end
`ifdef ACCU_ARB_TIMEOUT_EN
                // A stalled owner gives up the datapath; its partial group is dropped.
                else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    abort_d      = 1'b1;
                    sum_d        = '0;
                    beat_cnt_d   = '0;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
`endif
            end
            RESULT: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    last_grant_d = grant_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            sum_q        <= '0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            out_valid_q  <= 1'b0;
`ifdef ACCU_ARB_TIMEOUT_EN
            idle_cnt_q   <= '0;
            abort_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            sum_q        <= sum_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            out_valid_q  <= out_valid_d;
`ifdef ACCU_ARB_TIMEOUT_EN
            idle_cnt_q   <= idle_cnt_d;
            abort_q      <= abort_d;
`endif
        end
    end

    assign bus.req_ready = req_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign busy          = (state_q != IDLE);
`ifdef ACCU_ARB_TIMEOUT_EN
    assign abort         = abort_q;
`endif
endmodule

// File: doc/accu_arbiter.md
Name: accu_arbiter

Overview:
- Shares one group-of-four accumulator datapath among NUM_REQ requesters.
- A round-robin scheduler grants one requester at a time and locks the grant for a full group of GROUP beats.
- It accumulates the group and returns the sum tagged with the requester ID over a valid/ready result port.
- Sits between multiple sample producers and a single downstream sum consumer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of one input sample.
- GROUP, 4, beats per accumulation group (power of two, 2..16).
- TIMEOUT, 16, idle-cycle limit for a granted requester; used only with ACCU_ARB_TIMEOUT_EN.
- Derived localparams, not overridable: SUM_W = DATA_W + clog2(GROUP) (10 at defaults); ID_W = clog2(NUM_REQ).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester sample valid.
- req_data  in  NUM_REQ*DATA_W  packed samples; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  SUM_W  group sum.
- out_id  out  ID_W  requester that produced out_data.
- abort  out  1  present only with ACCU_ARB_TIMEOUT_EN.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 has top priority.
  - beat_cnt = 0, sum = 0, out_valid = 0, out_data = 0, out_id = 0, req_ready = 0, busy = 0.
- Reset applied mid-burst or mid-result discards all partial state; nothing is emitted.
- FSM states: IDLE, ACCUM, RESULT.
- IDLE:
  - req_ready all 0.
  - If any req_valid is high, the winner is the first set bit scanning last_grant+1, last_grant+2, ... with wrap.
  - Register grant_id = winner, clear beat_cnt, go to ACCUM. Arbitration costs exactly one cycle.
- ACCUM:
  - req_ready[grant_id] = 1 (combinational from state and grant_id); all other bits 0.
  - Beat accepted when req_valid[grant_id] & req_ready[grant_id].
  - First beat (beat_cnt = 0) loads sum = zero-extended data; later beats add it.
  - No beat: sum and beat_cnt hold. Other requesters' valids are ignored until the grant releases.
  - On the accepted beat with beat_cnt = GROUP-1:
    - out_data <= sum + data, out_id <= grant_id, out_valid <= 1; go to RESULT.
- RESULT:
  - out_valid high; out_data and out_id stable until out_valid & out_ready. out_ready may already be high on the first RESULT cycle.
  - On handshake: out_valid <= 0, last_grant <= grant_id, go to IDLE.
  - req_ready all 0 throughout.
- Latency: req_valid rising in IDLE at cycle T with continuous valid gives beats at T+1..T+GROUP and out_valid at T+GROUP+1. With out_ready held high, the next grant decision happens in IDLE at T+GROUP+2.
- Width: SUM_W holds GROUP*(2^DATA_W - 1) exactly, so there is no overflow or saturation (4*255 = 1020 at defaults).
- Fairness: a continuously requesting set is served in strict rotation; no requester waits more than NUM_REQ-1 groups.
- Simultaneous events: a req_valid change on the handshake cycle in RESULT only affects the arbitration in the following IDLE cycle.

Optional Feature:
- Macro ACCU_ARB_TIMEOUT_EN.
- Defined:
  - An idle counter clears on each accepted beat and on entry to ACCUM.
  - If it reaches TIMEOUT cycles in ACCUM with no accepted beat, discard the partial sum and pulse abort for one cycle.
  - Set last_grant <= grant_id and return to IDLE; no result is produced.
  - abort resets to 0.
- Undefined: the abort port and counter do not exist; ACCUM waits indefinitely.

Test Plan:
- Reset, then req0 streams 10, 20, 30, 40 continuously with out_ready = 1 -> out_valid one cycle at T+5, out_data = 100, out_id = 0, busy low again at T+6.
- req3 streams 255 x4 -> out_data = 1020, out_id = 3, no wrap.
- req0 and req2 continuously valid, distinct data -> results in order id 0, 2, 0, 2 with correct sums; req_ready[1] and req_ready[3] never high.
- out_ready low for 3 cycles in RESULT -> out_valid, out_data and out_id held constant; req_ready all 0; the next grant occurs only after the handshake.
- Granted req1 sends 2 beats (5, 6), drops valid for 5 cycles while req2 is valid, then sends 7, 8 -> out_data = 26, out_id = 1, then req2 granted. With ACCU_ARB_TIMEOUT_EN and TIMEOUT = 4 -> abort pulse, no out_valid, req2 granted next.
- rst asserted for 1 cycle mid-burst after 2 beats -> all outputs 0 the next cycle; a new burst from req0 returns the correct full-group sum with no carry-over.
